// File: rtl/rv32i_types.sv
// Shared types for the memory-side arbitration logic.
// arb_state_t  : arbiter FSM encoding (IDLE, GRANT_I, GRANT_D).
// mem_op_t     : operation latched for the granted transaction.
// arb_pick_d   : tie-break helper used when both caches request in IDLE.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  // Returns 1 when the D-cache should win the arbitration this cycle.
  // With rr_en clear, D always beats I. With rr_en set, a tie goes to the
  // side that was not granted last (last_was_i = 1 means I was granted last).
  function automatic logic arb_pick_d(input logic i_req,
                                      input logic d_req,
                                      input logic last_was_i,
                                      input logic rr_en);
    logic pick;
    if (!d_req) begin
      pick = 1'b0;
    end else if (!i_req) begin
      pick = 1'b1;
    end else if (rr_en) begin
      pick = last_was_i;
    end else begin
      pick = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter between the I-cache and D-cache line-fill/writeback ports and a
// single physical memory port. One transaction is in flight at a time; the
// winner's address, operation and write data are captured when the grant
// starts and drive the memory port for the whole grant. Responses are
// returned in the same cycle as mem_resp, and every grant is followed by
// one IDLE cycle.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to break simultaneous I/D
// requests in favour of the side not granted last. Without it, D has fixed
// priority over I and no pointer register exists.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_r;
  arb_state_t        state_s;

  logic [31:0]       addr_r;
  mem_op_t           op_r;
  logic [LINE_W-1:0] wdata_r;

  logic              d_req_s;
  logic              d_wins_s;
  logic              grant_i_s;
  logic              grant_d_s;
  logic              last_was_i_s;
  logic              i_resp_s;
  logic              d_resp_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;

  // Pointer: 1 when the most recent grant went to I; reset means "last = D".
  logic last_was_i_r;

  // Track which side was granted most recently for the tie-break.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_was_i_r <= 1'b0;
    end else if (grant_i_s) begin
      last_was_i_r <= 1'b1;
    end else if (grant_d_s) begin
      last_was_i_r <= 1'b0;
    end else begin
      last_was_i_r <= last_was_i_r;
    end
  end

  assign last_was_i_s = last_was_i_r;
`else
  localparam logic RR_EN = 1'b0;

  // Fixed priority: the pointer value is irrelevant and no register is built.
  assign last_was_i_s = 1'b0;
`endif

  // A writeback counts as a D request just like a fill.
  assign d_req_s  = d_read | d_write;
  assign d_wins_s = arb_pick_d(i_read, d_req_s, last_was_i_s, RR_EN);

  // Next-state, grant strobes and response pulses.
  always_comb begin
    state_s   = state_r;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    i_resp_s  = 1'b0;
    d_resp_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // mem_resp is ignored here: nothing is outstanding.
        if (d_wins_s) begin
          state_s   = GRANT_D;
          grant_d_s = 1'b1;
        end else if (i_read) begin
          state_s   = GRANT_I;
          grant_i_s = 1'b1;
        end else begin
          state_s   = IDLE;
        end
      end
      GRANT_I: begin
        // Requester dropping i_read does not abort the grant.
        if (mem_resp) begin
          i_resp_s = 1'b1;
          state_s  = IDLE;
        end else begin
          state_s  = GRANT_I;
        end
      end
      GRANT_D: begin
        if (mem_resp) begin
          d_resp_s = 1'b1;
          state_s  = IDLE;
        end else begin
          state_s  = GRANT_D;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture the winner's request at the start of a grant and hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= 32'h0000_0000;
      op_r    <= OP_READ;
      wdata_r <= {LINE_W{1'b0}};
    end else if (grant_d_s) begin
      // Read and write together is treated as a writeback.
      addr_r  <= d_addr;
      op_r    <= d_write ? OP_WRITE : OP_READ;
      wdata_r <= d_wdata;
    end else if (grant_i_s) begin
      addr_r  <= i_addr;
      op_r    <= OP_READ;
      wdata_r <= {LINE_W{1'b0}};
    end else begin
      addr_r  <= addr_r;
      op_r    <= op_r;
      wdata_r <= wdata_r;
    end
  end

  // Memory port is driven purely from the state and captured registers,
  // so it cannot glitch with requester inputs during a grant.
  assign mem_read  = (state_r != IDLE) && (op_r == OP_READ);
  assign mem_write = (state_r != IDLE) && (op_r == OP_WRITE);
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

  // Read data is a pass-through; it is meaningful only while resp is high.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_resp  = i_resp_s;
  assign d_resp  = d_resp_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a transaction-level
// reference model. Honors MEM_ARB_ROUND_ROBIN_EN for the tie-break rule.
module tb_mem_arbiter;

  localparam int LW = 256;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, mem_resp;
  logic [31:0]   i_addr, d_addr;
  logic [LW-1:0] d_wdata, mem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_resp, d_resp, mem_read, mem_write;
  logic [31:0]   mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns memory (0 none, 1 I, 2 D) and what it asked for.
  int            m_busy;
  logic [31:0]   m_addr;
  logic          m_write;
  logic [LW-1:0] m_wdata;
  logic          m_last_i;
  int            m_cnt;
  int            resp_delay;
  bit            spur_en;

  // Observations from the most recent cycle.
  logic          o_i_resp, o_d_resp, o_mem_read, o_mem_write;
  logic [31:0]   o_mem_addr;
  logic [LW-1:0] o_mem_wdata;
  int            n_iresp, n_dresp, cyc, i_resp_cyc;
  logic [32:0]   served[$];

  logic [LW-1:0] a5_line;
  logic [32:0]   exp0, exp1;
  int            nw;
  logic          ir_st, dr_st, dw_st, r_st;

  task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic ir, input logic dr, input logic dw,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [LW-1:0] wd, input logic r, input logic fr);
    logic          mr;
    logic [LW-1:0] rd;
    int            win;
    @(negedge clk);
    rd = rand_line();
    if (m_busy != 0) mr = (m_cnt == 0);
    else mr = fr || (spur_en && ($urandom_range(0, 7) == 0));
    i_read = ir; d_read = dr; d_write = dw; i_addr = ia; d_addr = da;
    d_wdata = wd; rst = r; mem_resp = mr; mem_rdata = rd;
    #1;
    check_eq("mem_read",  LW'(mem_read),  LW'((m_busy != 0) && !m_write));
    check_eq("mem_write", LW'(mem_write), LW'((m_busy != 0) && m_write));
    check_eq("mem_addr",  LW'(mem_addr),  LW'(m_addr));
    check_eq("mem_wdata", mem_wdata, m_wdata);
    check_eq("i_resp",    LW'(i_resp),    LW'((m_busy == 1) && mr));
    check_eq("d_resp",    LW'(d_resp),    LW'((m_busy == 2) && mr));
    check_eq("i_rdata",   i_rdata, rd);
    check_eq("d_rdata",   d_rdata, rd);
    o_i_resp = i_resp; o_d_resp = d_resp; o_mem_read = mem_read;
    o_mem_write = mem_write; o_mem_addr = mem_addr; o_mem_wdata = mem_wdata;
    if (i_resp) begin n_iresp++; i_resp_cyc = cyc; served.push_back({1'b0, mem_addr}); end
    if (d_resp) begin n_dresp++; served.push_back({1'b1, mem_addr}); end
    cyc++;
    // Advance the model to the state after this rising edge.
    if (r) begin
      m_busy = 0; m_addr = 32'h0; m_write = 1'b0; m_wdata = '0; m_last_i = 1'b0;
    end else if (m_busy == 0) begin
      win = 0;
      if (ir && (dr || dw)) win = (RR && !m_last_i) ? 1 : 2;
      else if (dr || dw)    win = 2;
      else if (ir)          win = 1;
      if (win == 2) begin m_addr = da; m_write = dw; m_wdata = wd; m_last_i = 1'b0; end
      if (win == 1) begin m_addr = ia; m_write = 1'b0; m_wdata = '0; m_last_i = 1'b1; end
      if (win != 0) begin
        m_busy = win;
        m_cnt  = (resp_delay > 0) ? resp_delay - 1 : int'($urandom_range(0, 4));
      end
    end else if (mr) begin
      m_busy = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
    end
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, {LW{1'b0}}, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, {LW{1'b0}}, 1'b1, 1'b0);
    idle_cycle();
    n_iresp = 0; n_dresp = 0; cyc = 0; i_resp_cyc = -1;
    served.delete();
  endtask

  // Both caches request in the same cycle; hold=1 keeps both requesting.
  task automatic run_tie(input logic [31:0] ia, input logic [31:0] da, input bit hold);
    served.delete(); n_iresp = 0; n_dresp = 0;
    for (int k = 0; k < 24; k++)
      cycle(hold || (n_iresp == 0), hold || (n_dresp == 0), 1'b0, ia, da, rand_line(), 1'b0, 1'b0);
  endtask

  initial begin
    a5_line = {(LW/8){8'hA5}};
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; i_addr = 32'h0; d_addr = 32'h0;
    d_wdata = '0; mem_resp = 1'b0; mem_rdata = '0; rst = 1'b1;
    m_busy = 0; m_addr = 32'h0; m_write = 1'b0; m_wdata = '0; m_last_i = 1'b0; m_cnt = 0;
    resp_delay = 3; spur_en = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    check_eq("rst_mem_addr", LW'(o_mem_addr), LW'(32'h0));
    check_eq("rst_mem_read", LW'(o_mem_read), LW'(1'b0));

    // I-cache fill, memory answers on the fifth grant cycle.
    resp_delay = 5;
    cycle(1'b1, 1'b0, 1'b0, 32'h60, 32'h0, {LW{1'b0}}, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cycle(n_iresp == 0, 1'b0, 1'b0, 32'h60, 32'h0, {LW{1'b0}}, 1'b0, 1'b0);
      if (k == 0) begin
        check_eq("t1_mem_read", LW'(o_mem_read), LW'(1'b1));
        check_eq("t1_mem_addr", LW'(o_mem_addr), LW'(32'h60));
      end
    end
    check_eq("t1_i_resp_count", LW'(n_iresp), LW'(1));
    check_eq("t1_i_resp_cycle", LW'(i_resp_cyc), LW'(5));
    check_eq("t1_d_resp_count", LW'(n_dresp), LW'(0));

    // Simultaneous requests from reset, then continuously held requests.
    do_reset();
    resp_delay = 3;
    run_tie(32'h200, 32'h100, 1'b0);
    exp0 = RR ? {1'b0, 32'h200} : {1'b1, 32'h100};
    exp1 = RR ? {1'b1, 32'h100} : {1'b0, 32'h200};
    check_eq("t2_served_count", LW'(served.size()), LW'(2));
    if (served.size() >= 2) begin
      check_eq("t2_first", LW'(served[0]), LW'(exp0));
      check_eq("t2_second", LW'(served[1]), LW'(exp1));
    end
    run_tie(32'h200, 32'h100, 1'b1);
    exp0 = RR ? {1'b0, 32'h200} : {1'b1, 32'h100};
    exp1 = {1'b1, 32'h100};
    check_eq("t3_served_enough", LW'(served.size() >= 2), LW'(1'b1));
    if (served.size() >= 2) begin
      check_eq("t3_first", LW'(served[0]), LW'(exp0));
      check_eq("t3_second", LW'(served[1]), LW'(exp1));
    end

    // Writeback data must stay captured while d_wdata changes.
    do_reset();
    resp_delay = 4; nw = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, n_dresp == 0, 32'h0, 32'h80, (k == 0) ? a5_line : rand_line(), 1'b0, 1'b0);
      if (o_mem_write) begin
        nw++;
        check_eq("t4_mem_wdata", o_mem_wdata, a5_line);
        check_eq("t4_mem_read", LW'(o_mem_read), LW'(1'b0));
      end
    end
    check_eq("t4_write_cycles", LW'(nw), LW'(4));
    check_eq("t4_d_resp_count", LW'(n_dresp), LW'(1));

    // Reset in the middle of an I grant, stray mem_resp right after.
    do_reset();
    resp_delay = 20;
    cycle(1'b1, 1'b0, 1'b0, 32'h60, 32'h0, {LW{1'b0}}, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h60, 32'h0, {LW{1'b0}}, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h60, 32'h0, {LW{1'b0}}, 1'b1, 1'b0);
    resp_delay = 3;
    cycle(1'b1, 1'b0, 1'b0, 32'h60, 32'h0, {LW{1'b0}}, 1'b0, 1'b1);
    check_eq("t5_mem_read_after_rst", LW'(o_mem_read), LW'(1'b0));
    check_eq("t5_no_i_resp", LW'(o_i_resp), LW'(1'b0));
    for (int k = 0; k < 8; k++) begin
      cycle(n_iresp == 0, 1'b0, 1'b0, 32'h60, 32'h0, {LW{1'b0}}, 1'b0, 1'b0);
      if (k == 0) check_eq("t5_regrant", LW'(o_mem_read), LW'(1'b1));
    end
    check_eq("t5_i_resp_count", LW'(n_iresp), LW'(1));

    // Read+write together is a write; dropped I request still completes.
    do_reset();
    resp_delay = 3;
    cycle(1'b0, 1'b1, 1'b1, 32'h0, 32'h40, rand_line(), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, n_dresp == 0, n_dresp == 0, 32'h0, 32'h40, rand_line(), 1'b0, 1'b0);
      if (k == 0) begin
        check_eq("t6_mem_write", LW'(o_mem_write), LW'(1'b1));
        check_eq("t6_mem_read", LW'(o_mem_read), LW'(1'b0));
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, {LW{1'b0}}, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) idle_cycle();
    check_eq("t6_i_resp_once", LW'(n_iresp), LW'(1));

    // Randomized traffic with stray mem_resp pulses and occasional reset.
    do_reset();
    resp_delay = -1; spur_en = 1'b1;
    ir_st = 1'b0; dr_st = 1'b0; dw_st = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) ir_st = ~ir_st;
      if ($urandom_range(0, 3) == 0) dr_st = ~dr_st;
      if ($urandom_range(0, 5) == 0) dw_st = ~dw_st;
      r_st = ($urandom_range(0, 63) == 0);
      cycle(ir_st, dr_st, dw_st, $urandom, $urandom, rand_line(), r_st, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_W, default 256, cache line width in bits.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_read  in  1  I-cache line fill request.
REQ-005 i_addr  in  32  I-cache line address.
REQ-006 i_rdata  out  LINE_W  line data to the I-cache.
REQ-007 i_resp  out  1  I-cache transaction complete.
REQ-008 d_read  in  1  D-cache line fill request.
REQ-009 d_write  in  1  D-cache writeback request.
REQ-010 d_addr  in  32  D-cache line address.
REQ-011 d_wdata  in  LINE_W  D-cache writeback data.
REQ-012 d_rdata  out  LINE_W  line data to the D-cache.
REQ-013 d_resp  out  1  D-cache transaction complete.
REQ-014 mem_read  out  1  physical memory read.
REQ-015 mem_write  out  1  physical memory write.
REQ-016 mem_addr  out  32  physical memory address.
REQ-017 mem_wdata  out  LINE_W  physical memory write data.
REQ-018 mem_rdata  in  LINE_W  physical memory read data.
REQ-019 mem_resp  in  1  physical memory transaction complete, one-cycle pulse.

Function
REQ-020 FSM states: IDLE, GRANT_I, GRANT_D; exactly one state at a time.
REQ-021 IDLE: mem_read = mem_write = 0, i_resp = d_resp = 0.
REQ-022 IDLE, i_read only -> GRANT_I next cycle.
REQ-023 IDLE, d_read or d_write only -> GRANT_D next cycle.
REQ-024 IDLE, I and D requests in the same cycle -> GRANT_D (fixed D priority, macro off).
REQ-025 On the IDLE->GRANT transition, latch the winner's address, op (read/write) and wdata into internal registers.
REQ-026 mem_addr, mem_wdata, mem_read, mem_write are driven only from the latched registers and are stable for the whole grant.
REQ-027 d_read and d_write both asserted: treat as write; d_read is ignored for that transaction.
REQ-028 GRANT_x: hold the memory request until mem_resp = 1.
REQ-029 mem_resp in GRANT_I: i_resp = 1 that same cycle, i_rdata = mem_rdata; next state IDLE.
REQ-030 mem_resp in GRANT_D: d_resp = 1 that same cycle, d_rdata = mem_rdata; next state IDLE.
REQ-031 i_rdata and d_rdata are a combinational pass-through of mem_rdata; they are valid only in the cycle their resp is high.
REQ-032 The non-granted requester's resp stays 0 throughout the grant.
REQ-033 A requester that drops its request mid-grant does not abort the grant: the transaction completes and resp still pulses.
REQ-034 After every resp there is one mandatory IDLE cycle; back-to-back grants are therefore 1 cycle apart, minimum.
REQ-035 Latency from request to mem_read/mem_write asserted: 1 cycle; from mem_resp to requester resp: 0 cycles.
REQ-036 mem_resp while in IDLE is ignored; no resp is generated.

Reset
REQ-037 rst forces IDLE and clears the latched address, op, wdata and priority pointer to 0 on the next edge, including mid-grant; the in-flight transaction is dropped and no resp is generated.
REQ-038 All memory-side and response outputs are 0 in the cycle after rst is sampled.

Configuration
REQ-039 Macro MEM_ARB_ROUND_ROBIN_EN defined: a 1-bit last-granted pointer breaks simultaneous I/D requests in favour of the side not granted last; the pointer resets to "last = D", so the first tie grants I.
REQ-040 MEM_ARB_ROUND_ROBIN_EN undefined: fixed D-over-I priority per REQ-024; no pointer register is built.

Structure
REQ-041 The arb_state_t enum (IDLE, GRANT_I, GRANT_D) is placed in rv32i_types.
REQ-042 There is no sub-module; the FSM, latch registers and output muxing are in mem_arbiter.

Verification
REQ-043 i_read = 1, i_addr = 0x00000060; memory responds after 5 cycles -> mem_read = 1 and mem_addr = 0x60 one cycle after the request; i_resp = 1 for exactly one cycle with i_rdata = mem_rdata; d_resp = 0 throughout.
REQ-044 i_read and d_read rise in the same cycle (d_addr = 0x100, i_addr = 0x200), macro off -> D served first at 0x100; I served at 0x200 after one IDLE cycle.
REQ-045 Same stimulus as REQ-044, macro on, from reset -> I served first; on the next tie, D is served first.
REQ-046 d_write = 1, d_addr = 0x80, d_wdata = all 0xA5 bytes; d_wdata changes during the grant -> mem_wdata stays at all 0xA5 until mem_resp; mem_write = 1 and mem_read = 0.
REQ-047 rst asserted 2 cycles into GRANT_I; mem_resp pulses the following cycle -> mem_read = 0 next cycle and no i_resp; i_read is re-granted normally after rst is released.
REQ-048 d_read and d_write both = 1 -> only mem_write is asserted; i_read dropped mid-grant -> i_resp still pulses once.
